// File: rtl/ex_mem_stage.sv
// Execute-to-memory stage: result select, CC register, condition eval, E->M pipeline register.
// Latency: 1 cycle E->M; e_cnd is combinational from the registered cc.
// Backpressure: m_stall holds M and cc, m_bubble inserts a nop; EX_PERF_CNT_EN adds op_cnt/jnt_cnt.
module ex_mem_stage #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        e_stat,
  input  logic [3:0]        e_icode,
  input  logic [3:0]        e_ifun,
  input  logic [DATA_W-1:0] alu_s,
  input  logic [DATA_W-1:0] alu_ans,
  input  logic              alu_ovf,
  input  logic [DATA_W-1:0] e_valA,
  input  logic [3:0]        e_dstE,
  input  logic [3:0]        e_dstM,
  input  logic              cc_block,
  input  logic              m_stall,
  input  logic              m_bubble,
  output logic              e_cnd,
  output logic [2:0]        cc,
  output logic [3:0]        M_stat,
  output logic [3:0]        M_icode,
  output logic              M_cnd,
  output logic [DATA_W-1:0] M_valE,
  output logic [DATA_W-1:0] M_valA,
  output logic [3:0]        M_dstE,
  output logic [3:0]        M_dstM
`ifdef EX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  op_cnt,
  output logic [CNT_W-1:0]  jnt_cnt
`endif
);

  localparam logic [3:0] I_NOP  = 4'h1;
  localparam logic [3:0] I_CMOV = 4'h2;
  localparam logic [3:0] I_OPQ  = 4'h6;
  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] S_AOK  = 4'h1;
  localparam logic [3:0] R_NONE = 4'hF;

  typedef struct packed {
    logic [3:0]        stat;
    logic [3:0]        icode;
    logic              cnd;
    logic [DATA_W-1:0] val_e;
    logic [DATA_W-1:0] val_a;
    logic [3:0]        dst_e;
    logic [3:0]        dst_m;
  } m_reg_t;

  localparam m_reg_t M_NOP = '{
    stat:  S_AOK,
    icode: I_NOP,
    cnd:   1'b0,
    val_e: '0,
    val_a: '0,
    dst_e: R_NONE,
    dst_m: R_NONE
  };

  logic [DATA_W-1:0] val_e;
  logic [3:0]        dst_e_eff;
  logic              zf, sf, of, lt;
  logic              load_ok;
  logic              cc_upd;
  m_reg_t            m_q;
  m_reg_t            m_d;

  // ifun[1] separates the logic ops (and/xor) from the arithmetic ones (add/sub)
  assign val_e = e_ifun[1] ? alu_ans : alu_s;

  assign zf = cc[2];
  assign sf = cc[1];
  assign of = cc[0];
  assign lt = sf ^ of;

  always_comb begin
    e_cnd = 1'b0;
    case (e_ifun)
      4'd0:    e_cnd = 1'b1;
      4'd1:    e_cnd = lt | zf;
      4'd2:    e_cnd = lt;
      4'd3:    e_cnd = zf;
      4'd4:    e_cnd = ~zf;
      4'd5:    e_cnd = ~lt;
      4'd6:    e_cnd = ~lt & ~zf;
      default: e_cnd = 1'b0;
    endcase
  end

  assign dst_e_eff = (e_icode == I_CMOV && !e_cnd) ? R_NONE : e_dstE;

  assign load_ok = !m_stall && !m_bubble;
  assign cc_upd  = load_ok && !cc_block && (e_icode == I_OPQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      cc <= 3'b100;
    end else if (cc_upd) begin
      cc <= {(val_e == '0), val_e[DATA_W-1], (alu_ovf & ~e_ifun[1])};
    end
  end

  always_comb begin
    m_d       = m_q;
    m_d.stat  = e_stat;
    m_d.icode = e_icode;
    m_d.cnd   = e_cnd;
    m_d.val_e = val_e;
    m_d.val_a = e_valA;
    m_d.dst_e = dst_e_eff;
    m_d.dst_m = e_dstM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= M_NOP;
    end else if (m_stall) begin
      m_q <= m_q;
    end else if (m_bubble) begin
      m_q <= M_NOP;
    end else begin
      m_q <= m_d;
    end
  end

  assign M_stat  = m_q.stat;
  assign M_icode = m_q.icode;
  assign M_cnd   = m_q.cnd;
  assign M_valE  = m_q.val_e;
  assign M_valA  = m_q.val_a;
  assign M_dstE  = m_q.dst_e;
  assign M_dstM  = m_q.dst_m;

`ifdef EX_PERF_CNT_EN
  // Counters only see instructions that actually enter M
  always_ff @(posedge clk) begin
    if (rst) begin
      op_cnt  <= '0;
      jnt_cnt <= '0;
    end else if (load_ok) begin
      if (e_icode == I_OPQ) op_cnt <= op_cnt + 1'b1;
      if (e_icode == I_JXX && !e_cnd) jnt_cnt <= jnt_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: reset state, result select, CC/cond eval, cmov, stall/bubble, counters.
module tb_ex_mem_stage;

  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        e_stat, e_icode, e_ifun, e_dstE, e_dstM;
  logic [DATA_W-1:0] alu_s, alu_ans, e_valA;
  logic              alu_ovf, cc_block, m_stall, m_bubble;
  logic              e_cnd, M_cnd;
  logic [2:0]        cc;
  logic [3:0]        M_stat, M_icode, M_dstE, M_dstM;
  logic [DATA_W-1:0] M_valE, M_valA;

  int vectors     = 0;
  int miscompares = 0;

`ifdef EX_PERF_CNT_EN
  logic [31:0] op_cnt, jnt_cnt;
  logic [1:0]  op_cnt2, jnt_cnt2;
  logic        e_cnd2, M_cnd2;
  logic [2:0]  cc2;
  logic [3:0]  M_stat2, M_icode2, M_dstE2, M_dstM2;
  logic [DATA_W-1:0] M_valE2, M_valA2;
`endif

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_W(DATA_W), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .e_stat(e_stat), .e_icode(e_icode), .e_ifun(e_ifun),
    .alu_s(alu_s), .alu_ans(alu_ans), .alu_ovf(alu_ovf), .e_valA(e_valA),
    .e_dstE(e_dstE), .e_dstM(e_dstM), .cc_block(cc_block), .m_stall(m_stall),
    .m_bubble(m_bubble), .e_cnd(e_cnd), .cc(cc), .M_stat(M_stat), .M_icode(M_icode),
    .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
`ifdef EX_PERF_CNT_EN
    , .op_cnt(op_cnt), .jnt_cnt(jnt_cnt)
`endif
  );

`ifdef EX_PERF_CNT_EN
  ex_mem_stage #(.DATA_W(DATA_W), .CNT_W(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .e_stat(e_stat), .e_icode(e_icode), .e_ifun(e_ifun),
    .alu_s(alu_s), .alu_ans(alu_ans), .alu_ovf(alu_ovf), .e_valA(e_valA),
    .e_dstE(e_dstE), .e_dstM(e_dstM), .cc_block(cc_block), .m_stall(m_stall),
    .m_bubble(m_bubble), .e_cnd(e_cnd2), .cc(cc2), .M_stat(M_stat2), .M_icode(M_icode2),
    .M_cnd(M_cnd2), .M_valE(M_valE2), .M_valA(M_valA2), .M_dstE(M_dstE2), .M_dstM(M_dstM2),
    .op_cnt(op_cnt2), .jnt_cnt(jnt_cnt2)
  );
`endif

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock edge, then settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_e(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] s, input logic [63:0] ans, input logic ovf,
                       input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm);
    e_icode = icode; e_ifun = ifun; alu_s = s; alu_ans = ans; alu_ovf = ovf;
    e_valA = va; e_dstE = de; e_dstM = dm;
    #1;
  endtask

  initial begin
    rst = 1'b1; e_stat = 4'h1; cc_block = 1'b0; m_stall = 1'b0; m_bubble = 1'b0;
    set_e(4'h1, 4'h0, 64'h0, 64'h0, 1'b0, 64'h0, 4'hF, 4'hF);
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst_icode", M_icode, 4'h1);
    chk("rst_dstE",  M_dstE,  4'hF);
    chk("rst_dstM",  M_dstM,  4'hF);
    chk("rst_stat",  M_stat,  4'h1);
    chk("rst_valE",  M_valE,  64'h0);
    chk("rst_cc",    cc,      3'b100);
    e_ifun = 4'd3; #1; chk("rst_cnd_e",  e_cnd, 1'b1);
    e_ifun = 4'd6; #1; chk("rst_cnd_g",  e_cnd, 1'b0);
    e_ifun = 4'd5; #1; chk("rst_cnd_ge", e_cnd, 1'b1);

    // OPq sub giving zero
    set_e(4'h6, 4'h1, 64'h0, 64'h77, 1'b0, 64'h11, 4'h2, 4'hF);
    chk("sub_cnd_pre", e_cnd, 1'b1);
    step();
    chk("sub_valE",  M_valE,  64'h0);
    chk("sub_icode", M_icode, 4'h6);
    chk("sub_dstE",  M_dstE,  4'h2);
    chk("sub_valA",  M_valA,  64'h11);
    chk("sub_cc",    cc,      3'b100);

    // OPq add, negative with overflow
    set_e(4'h6, 4'h0, 64'h8000_0000_0000_0000, 64'h0, 1'b1, 64'h0, 4'h2, 4'hF);
    step();
    chk("add_valE", M_valE, 64'h8000_0000_0000_0000);
    chk("add_cc",   cc,     3'b011);
    e_ifun = 4'd2; #1; chk("cc011_cnd_l", e_cnd, 1'b0);

    // OPq xor picks ans, OF forced low; same-cycle OPq does not affect e_cnd
    set_e(4'h6, 4'h3, 64'h99, 64'h5, 1'b1, 64'h0, 4'h4, 4'hF);
    chk("xor_cnd_pre", e_cnd, 1'b0);
    step();
    chk("xor_valE", M_valE, 64'h5);
    chk("xor_cc",   cc,     3'b000);
    chk("xor_cnd",  M_cnd,  1'b0);

    // cmovle not taken with cc=000
    set_e(4'h2, 4'h1, 64'h42, 64'h0, 1'b0, 64'h42, 4'h3, 4'hF);
    chk("cmov_nt_cnd_e", e_cnd, 1'b0);
    step();
    chk("cmov_nt_dstE", M_dstE, 4'hF);
    chk("cmov_nt_cnd",  M_cnd,  1'b0);
    chk("cmov_nt_cc",   cc,     3'b000);

    // Build cc=010 and sweep the condition decoder
    set_e(4'h6, 4'h0, 64'h8000_0000_0000_0001, 64'h0, 1'b0, 64'h0, 4'h1, 4'hF);
    step();
    chk("neg_cc", cc, 3'b010);
    e_icode = 4'h1;
    e_ifun = 4'd0; #1; chk("cnd_always", e_cnd, 1'b1);
    e_ifun = 4'd4; #1; chk("cnd_ne",     e_cnd, 1'b1);
    e_ifun = 4'd5; #1; chk("cnd_ge",     e_cnd, 1'b0);
    e_ifun = 4'd6; #1; chk("cnd_g",      e_cnd, 1'b0);
    e_ifun = 4'd7; #1; chk("cnd_7",      e_cnd, 1'b0);
    e_ifun = 4'd15; #1; chk("cnd_15",    e_cnd, 1'b0);

    // cmovle taken with cc=010
    set_e(4'h2, 4'h1, 64'h42, 64'h0, 1'b0, 64'h42, 4'h3, 4'hF);
    step();
    chk("cmov_t_dstE", M_dstE, 4'h3);
    chk("cmov_t_cnd",  M_cnd,  1'b1);
    chk("cmov_t_valE", M_valE, 64'h42);

    // Stall and bubble together: stall wins, no CC update
    set_e(4'h6, 4'h0, 64'h0, 64'h0, 1'b0, 64'h9, 4'h5, 4'h6);
    m_stall = 1'b1; m_bubble = 1'b1;
    step();
    chk("sb_icode", M_icode, 4'h2);
    chk("sb_dstE",  M_dstE,  4'h3);
    chk("sb_valE",  M_valE,  64'h42);
    chk("sb_cc",    cc,      3'b010);

    // Bubble only
    m_stall = 1'b0;
    step();
    chk("bub_icode", M_icode, 4'h1);
    chk("bub_dstE",  M_dstE,  4'hF);
    chk("bub_dstM",  M_dstM,  4'hF);
    chk("bub_valE",  M_valE,  64'h0);
    chk("bub_cnd",   M_cnd,   1'b0);
    chk("bub_cc",    cc,      3'b010);

    // cc_block: M loads, cc holds
    m_bubble = 1'b0; cc_block = 1'b1; e_stat = 4'h2;
    step();
    chk("blk_icode", M_icode, 4'h6);
    chk("blk_dstE",  M_dstE,  4'h5);
    chk("blk_dstM",  M_dstM,  4'h6);
    chk("blk_stat",  M_stat,  4'h2);
    chk("blk_cc",    cc,      3'b010);
    cc_block = 1'b0; e_stat = 4'h1;

    // Reset overrides an active stall
    m_stall = 1'b1; rst = 1'b1;
    step();
    chk("rst_stall_icode", M_icode, 4'h1);
    chk("rst_stall_dstE",  M_dstE,  4'hF);
    chk("rst_stall_cc",    cc,      3'b100);
    m_stall = 1'b0; rst = 1'b0;

`ifdef EX_PERF_CNT_EN
    rst = 1'b1; step(); rst = 1'b0;
    chk("cnt_rst_op", op_cnt, 32'd0);
    set_e(4'h6, 4'h0, 64'h1, 64'h0, 1'b0, 64'h0, 4'h1, 4'hF);
    step(); step(); step();
    m_stall = 1'b1; step(); m_stall = 1'b0;
    set_e(4'h7, 4'h3, 64'h0, 64'h0, 1'b0, 64'h0, 4'hF, 4'hF);
    step(); step();
    set_e(4'h7, 4'h0, 64'h0, 64'h0, 1'b0, 64'h0, 4'hF, 4'hF);
    step();
    chk("cnt_op",     op_cnt,   32'd3);
    chk("cnt_jnt",    jnt_cnt,  32'd2);
    chk("cnt_op_w2",  op_cnt2,  2'd3);
    set_e(4'h6, 4'h0, 64'h1, 64'h0, 1'b0, 64'h0, 4'h1, 4'hF);
    step(); step();
    chk("cnt_op5",    op_cnt,   32'd5);
    chk("cnt_op_wrap", op_cnt2, 2'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Sits directly downstream of the pipeline ALU.
- Selects the execute result from the ALU's two result buses (S for add/sub, ans for and/xor).
- Owns the condition-code register (ZF, SF, OF) and evaluates the branch/cmov condition.
- Registers all execute-stage outputs into the E->M pipeline register, with stall/bubble control from the pipeline hazard logic.

Parameters:
- DATA_W, 64, data path width; must match the ALU width.
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- e_stat  in  4  stat code of the instruction in E
- e_icode  in  4  icode in E
- e_ifun  in  4  ifun in E; ifun[1:0] equals the ALU control code for OPq
- alu_s  in  DATA_W  ALU S output (add/sub result)
- alu_ans  in  DATA_W  ALU ans output (and/xor result)
- alu_ovf  in  1  ALU overflow output
- e_valA  in  DATA_W  valA in E
- e_dstE  in  4  dstE in E
- e_dstM  in  4  dstM in E
- cc_block  in  1  exception downstream (M or W stat not AOK); suppresses CC update
- m_stall  in  1  hold the M register
- m_bubble  in  1  load a nop into the M register
- e_cnd  out  1  combinational condition result for the instruction in E
- cc  out  3  {ZF,SF,OF}, registered
- M_stat  out  4  registered stat
- M_icode  out  4  registered icode
- M_cnd  out  1  registered condition result
- M_valE  out  DATA_W  registered execute result
- M_valA  out  DATA_W  registered valA
- M_dstE  out  4  registered dstE
- M_dstM  out  4  registered dstM

Behaviour:
- Result select:
  - valE = alu_s when e_ifun[1:0] is 0 or 1; alu_ans when e_ifun[1:0] is 2 or 3.
  - Selection is purely combinational; no arithmetic in this block.
- CC update:
  - Condition: rising edge with e_icode==6 (OPq), rst==0, cc_block==0, m_stall==0 and m_bubble==0.
  - ZF = (valE==0).
  - SF = valE[DATA_W-1].
  - OF = alu_ovf when ifun[1:0]<2, else 0.
  - Otherwise cc holds.
- e_cnd, computed from the current registered cc and e_ifun:
  - 0: 1
  - 1 (le): (SF^OF)|ZF
  - 2 (l): SF^OF
  - 3 (e): ZF
  - 4 (ne): ~ZF
  - 5 (ge): ~(SF^OF)
  - 6 (g): ~(SF^OF)&~ZF
  - 7..15: 0
  - An OPq in the same cycle does NOT affect e_cnd; the new flags are visible from the next cycle.
- Effective dstE: 0xF when e_icode==2 (cmovXX) and e_cnd==0; else e_dstE.
- M register, latency 1 cycle:
  - Priority on the clock edge is rst > m_stall > m_bubble > normal load.
  - Stall: all M_* hold.
  - Bubble: M_icode=1 (nop), M_stat=1 (AOK), M_cnd=0, M_valE=0, M_valA=0, M_dstE=0xF, M_dstM=0xF.
  - Normal load: M_valE=valE, M_cnd=e_cnd, M_dstE=effective dstE, other fields pass through.
- Reset:
  - All M_* take the bubble values.
  - cc = {ZF=1, SF=0, OF=0}.
  - Reset asserted mid-stall overrides the stall.
- Simultaneous m_stall and m_bubble: stall wins, and the CC update is also suppressed.

Optional Feature:
- Macro EX_PERF_CNT_EN.
- When defined, two extra output ports exist: op_cnt (CNT_W) and jnt_cnt (CNT_W).
- op_cnt increments on every normal M load with e_icode==6.
- jnt_cnt increments on every normal M load with e_icode==7 and e_cnd==0.
- Neither counter increments on stall, bubble or reset; both clear to 0 on rst and wrap modulo 2^CNT_W.
- When undefined, the ports and counter logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset then idle: after rst pulse -> M_icode=1, M_dstE=0xF, M_stat=1, cc=3'b100, e_cnd with ifun=3 is 1.
- OPq sub (ifun=1), alu_s=0, alu_ovf=0 -> next cycle M_valE=0, cc=3'b100. Then add (ifun=0) with alu_s=0x8000000000000000, alu_ovf=1 -> cc=3'b011.
- xor (ifun=3), alu_ans=0x5, alu_s=0x99, alu_ovf=1 -> M_valE=0x5, cc=3'b000 (OF forced 0).
- cmovle (icode=2, ifun=1) with cc=3'b000, e_dstE=3 -> M_dstE=0xF, M_cnd=0. With cc=3'b010 -> M_dstE=3, M_cnd=1.
- OPq with m_stall=1 and m_bubble=1 simultaneously -> M_* and cc unchanged. OPq with m_bubble only -> M holds nop values, cc unchanged. OPq with cc_block=1 -> M loads, cc unchanged.
- EX_PERF_CNT_EN defined: 3 OPq loads, 1 stalled OPq, 2 jXX with cnd=0, 1 jmp -> op_cnt=3, jnt_cnt=2. With CNT_W=2 and 5 OPq loads -> op_cnt=1 (wraps).
